// File: rtl/spram_banked.sv
// Linear word-addressed RAM over 1, 2 or 4 SPRAM banks with valid/ready handshake, nibble
// write mask, post-reset zero clear and per-bank idle sleep with automatic wake.
module spram_banked #(
    parameter int unsigned BANKS          = 2,
    parameter int unsigned CLEAR_ON_RESET = 1,
    parameter int unsigned SLEEP_IDLE     = 256,
    parameter int unsigned WAKE_CYCLES    = 3,
    localparam int unsigned AW            = 14 + $clog2(BANKS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   in,
    input  logic [3:0]    wmask,
    output logic          ready,
    output logic [15:0]   out,
    output logic          rvalid,
    output logic          init_done
);
    localparam int unsigned BW = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int unsigned CW = (SLEEP_IDLE > 0) ? $clog2(SLEEP_IDLE + 1) : 1;
    localparam logic [CW-1:0] IdleMax  = CW'(SLEEP_IDLE);
    localparam logic [3:0]    WakeLast = 4'(WAKE_CYCLES - 1);

    if (BANKS != 1 && BANKS != 2 && BANKS != 4) begin : g_bad_banks
        $error("spram_banked: BANKS must be 1, 2 or 4");
    end
    if (WAKE_CYCLES < 1 || WAKE_CYCLES > 15) begin : g_bad_wake
        $error("spram_banked: WAKE_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {StClear, StRun, StWake} state_e;

    state_e           state_q, state_d;
    logic [13:0]      clr_q, clr_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic [BW-1:0]    bsel, wake_bank, wbank_q, wbank_d, rd_bank_q;
    logic             rd_pend_q, init_q, init_d;
    logic [15:0]      hold_q;
    logic [CW-1:0]    idle_q [BANKS];
    logic [CW-1:0]    idle_d [BANKS];
    logic [BANKS-1:0] asleep, ram_wren, ram_sleep;
    logic [13:0]      ram_addr;
    logic [15:0]      ram_din;
    logic [3:0]       ram_mask;
    logic [15:0]      ram_dout [BANKS];
    logic             clearing, accept, detect, wake_done;

    if (BANKS == 1) begin : g_one_bank
        assign bsel = '0;
    end else begin : g_multi_bank
        assign bsel = addr[AW-1:14];
    end

    always_comb begin
        for (int b = 0; b < BANKS; b++) begin
            asleep[b] = (SLEEP_IDLE != 0) && (idle_q[b] == IdleMax);
        end
    end

    always_comb begin
        clearing  = rst_n && (state_q == StClear);
        ready     = rst_n && (state_q == StRun) && !asleep[bsel];
        accept    = req && ready;
        detect    = rst_n && (state_q == StRun) && req && asleep[bsel];
        wake_bank = (state_q == StWake) ? wbank_q : bsel;

        state_d   = state_q;
        clr_d     = clr_q;
        wcnt_d    = wcnt_q;
        wbank_d   = wbank_q;
        wake_done = 1'b0;
        case (state_q)
            StClear: begin
                clr_d = clr_q + 14'd1;
                if (clr_q == 14'h3fff) state_d = StRun;
            end
            StRun: begin
                // The detect cycle already counts as the first cycle out of SLEEP.
                if (detect) begin
                    wbank_d = bsel;
                    wcnt_d  = 4'd1;
                    if (WakeLast == 4'd0) wake_done = 1'b1;
                    else state_d = StWake;
                end
            end
            StWake: begin
                if (wcnt_q == WakeLast) begin
                    state_d   = StRun;
                    wake_done = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            default: state_d = StRun;
        endcase
        init_d = init_q || (state_d == StRun);
    end

    always_comb begin
        for (int b = 0; b < BANKS; b++) begin
            if (state_q == StClear) begin
                idle_d[b] = '0;
            end else if ((accept && bsel == BW'(b)) || (wake_done && wake_bank == BW'(b))) begin
                idle_d[b] = '0;
            end else if (idle_q[b] != IdleMax) begin
                idle_d[b] = idle_q[b] + CW'(1);
            end else begin
                idle_d[b] = idle_q[b];
            end
        end
    end

    always_comb begin
        ram_addr = clearing ? clr_q : addr[13:0];
        ram_din  = clearing ? 16'h0000 : in;
        ram_mask = clearing ? 4'hf : wmask;
        for (int b = 0; b < BANKS; b++) begin
            ram_wren[b]  = clearing || (accept && we && bsel == BW'(b));
            ram_sleep[b] = asleep[b] && !((detect || state_q == StWake) && wake_bank == BW'(b));
        end
    end

    // Behavioural stand-in for SB_SPRAM256KA; CHIPSELECT and POWEROFF tied high, STANDBY low.
    for (genvar g = 0; g < BANKS; g++) begin : g_bank
        logic [15:0] mem [16384];
        logic [15:0] dout_q;
        always_ff @(posedge clk) begin
            if (!ram_sleep[g]) begin
                if (ram_wren[g]) begin
                    for (int n = 0; n < 4; n++) begin
                        if (ram_mask[n]) mem[ram_addr][4*n +: 4] <= ram_din[4*n +: 4];
                    end
                end else begin
                    dout_q <= mem[ram_addr];
                end
            end
        end
        assign ram_dout[g] = dout_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? StClear : StRun;
            clr_q     <= '0;
            wcnt_q    <= '0;
            wbank_q   <= '0;
            rd_bank_q <= '0;
            rd_pend_q <= 1'b0;
            init_q    <= 1'b0;
            hold_q    <= '0;
            for (int b = 0; b < BANKS; b++) idle_q[b] <= '0;
        end else begin
            state_q   <= state_d;
            clr_q     <= clr_d;
            wcnt_q    <= wcnt_d;
            wbank_q   <= wbank_d;
            init_q    <= init_d;
            rd_pend_q <= accept && !we;
            if (accept && !we) rd_bank_q <= bsel;
            // Bank DATAOUT follows every non-write cycle, so the completed read is captured here.
            if (rd_pend_q) hold_q <= ram_dout[rd_bank_q];
            for (int b = 0; b < BANKS; b++) idle_q[b] <= idle_d[b];
        end
    end

    assign rvalid    = rd_pend_q;
    assign out       = rd_pend_q ? ram_dout[rd_bank_q] : hold_q;
    assign init_done = init_q;

endmodule

// File: tb/tb_spram_banked.sv
// Bench for spram_banked (2 banks, 8-cycle sleep, 3-cycle wake): a per-cycle reference model
// plus directed transactions with literal expectations.
module tb_spram_banked;
    localparam int SI    = 8;
    localparam int WC    = 3;
    localparam int WORDS = 32768;

    logic        clk = 1'b0;
    logic        rst_n, req, we;
    logic [14:0] addr;
    logic [15:0] din, dout;
    logic [3:0]  wmask;
    logic        ready, rvalid, init_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spram_banked #(
        .BANKS(2), .CLEAR_ON_RESET(1), .SLEEP_IDLE(SI), .WAKE_CYCLES(WC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .in(din), .wmask(wmask),
        .ready(ready), .out(dout), .rvalid(rvalid), .init_done(init_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: word array, cycles since each bank was last touched, wake countdown.
    bit          known = 0, run_ph = 0, rd_pend_m = 0;
    int          clear_left = 0, wake_left = 0, wake_bank = 0;
    int          idle_m [2];
    logic [15:0] out_m = '0;
    logic [15:0] ref_mem [WORDS];

    always @(negedge clk) begin
        int          b;
        bit          exp_ready;
        bit          touch [2];
        logic [15:0] w;
        b = int'(addr[14]);
        if (known) begin
            exp_ready = rst_n && run_ph && wake_left == 0 && idle_m[b] < SI;
            chk("ready", 32'(ready), 32'(exp_ready));
            chk("init_done", 32'(init_done), 32'(run_ph));
            chk("rvalid", 32'(rvalid), 32'(rd_pend_m));
            chk("out", 32'(dout), 32'(out_m));
        end
        if (!rst_n) begin
            known      = 1;
            run_ph     = 0;
            clear_left = 16384;
            wake_left  = 0;
            rd_pend_m  = 0;
            out_m      = '0;
            idle_m     = '{0, 0};
            for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
        end else if (known && !run_ph) begin
            clear_left--;
            if (clear_left == 0) run_ph = 1;
        end else if (known) begin
            touch     = '{0, 0};
            rd_pend_m = 0;
            if (wake_left > 0) begin
                wake_left--;
                if (wake_left == 0) touch[wake_bank] = 1;
            end else if (req && idle_m[b] < SI) begin
                touch[b] = 1;
                if (we) begin
                    w = ref_mem[addr];
                    for (int n = 0; n < 4; n++) if (wmask[n]) w[4*n +: 4] = din[4*n +: 4];
                    ref_mem[addr] = w;
                end else begin
                    rd_pend_m = 1;
                    out_m     = ref_mem[addr];
                end
            end else if (req) begin
                wake_bank = b;
                wake_left = WC - 1;
                if (wake_left == 0) touch[b] = 1;
            end
            for (int k = 0; k < 2; k++) begin
                idle_m[k] = touch[k] ? 0 : ((idle_m[k] < SI) ? idle_m[k] + 1 : SI);
            end
        end
    end

    // Waits (bounded) until the current request is accepted; returns the cycles ready was low.
    task automatic wait_accept(output int low);
        low = 0;
        forever begin
            @(negedge clk);
            if (ready) break;
            low++;
            if (low > 40) begin
                chk("accept_timeout", 32'(low), 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [14:0] a, input logic [15:0] d, input logic [3:0] m);
        int low;
        req = 1; we = 1; addr = a; din = d; wmask = m;
        wait_accept(low);
        req = 0; we = 0;
    endtask

    task automatic rd(input string name, input logic [14:0] a, input logic [15:0] exp,
                      output int low);
        req = 1; we = 0; addr = a;
        wait_accept(low);
        req = 0;
        chk({name, "_rvalid"}, 32'(rvalid), 32'd1);
        chk({name, "_data"}, 32'(dout), 32'(exp));
    endtask

    task automatic count_clear(input string name);
        int n;
        bit seen_ready;
        n = 0;
        seen_ready = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (!init_done && ready) seen_ready = 1;
        end while (!init_done && n < 20000);
        chk({name, "_clear_cycles"}, 32'(n), 32'd16384);
        chk({name, "_ready_in_clear"}, 32'(seen_ready), 32'd0);
    endtask

    initial begin
        int low;
        rst_n = 0; req = 0; we = 0; addr = '0; din = '0; wmask = '0;
        @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_out", 32'(dout), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        count_clear("first");

        rd("clr_0", 15'd0, 16'h0000, low);
        rd("clr_16383", 15'd16383, 16'h0000, low);
        rd("clr_16384", 15'd16384, 16'h0000, low);
        rd("clr_32767", 15'd32767, 16'h0000, low);

        wr(15'h4005, 16'hBEEF, 4'hf);
        rd("beef", 15'h4005, 16'hBEEF, low);
        rd("alias", 15'h0005, 16'h0000, low);

        wr(15'd7, 16'h1234, 4'hf);
        wr(15'd7, 16'hABCD, 4'b0101);
        rd("mask", 15'd7, 16'h1B3D, low);
        wr(15'd2, 16'h0000, 4'b0000);

        wr(15'd1, 16'h0011, 4'hf);
        wr(15'd2, 16'h0022, 4'hf);
        wr(15'd3, 16'h0033, 4'hf);
        req = 1; we = 0; addr = 15'd1;
        @(negedge clk) chk("b2b_ready1", 32'(ready), 32'd1);
        @(posedge clk);
        #1 addr = 15'd2;
        chk("b2b_out1", 32'({rvalid, dout}), 32'h10011);
        @(negedge clk) chk("b2b_ready2", 32'(ready), 32'd1);
        @(posedge clk);
        #1 addr = 15'd3;
        chk("b2b_out2", 32'({rvalid, dout}), 32'h10022);
        @(negedge clk) chk("b2b_ready3", 32'(ready), 32'd1);
        @(posedge clk);
        #1 req = 0;
        chk("b2b_out3", 32'({rvalid, dout}), 32'h10033);
        @(posedge clk);
        #1 chk("b2b_hold", 32'({rvalid, dout}), 32'h00033);

        repeat (10) rd("keep_bank0", 15'd1, 16'h0011, low);
        rd("wake_read", 15'd16384, 16'h0000, low);
        chk("wake_ready_low", 32'(low), 32'(WC));
        rd("after_wake", 15'h4005, 16'hBEEF, low);
        chk("awake_ready_low", 32'(low), 32'd0);

        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (100) @(posedge clk);
        #1 rst_n = 0;
        repeat (2) @(posedge clk);
        #1 chk("midclr_init_done", 32'(init_done), 32'd0);
        rst_n = 1;
        count_clear("restart");
        rd("wiped_7", 15'd7, 16'h0000, low);
        rd("wiped_4005", 15'h4005, 16'h0000, low);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/spram_banked.md
Name: spram_banked

Overview:
Parametrised main-memory block built from 1, 2 or 4 iCE40UP5K SB_SPRAM256KA primitives (16K x 16 each), presented as one linear word-addressed RAM. Adds over the single-bank RAM16K:
- valid/ready request handshake with a read-valid strobe;
- per-nibble write mask;
- zero-clear of all contents after reset;
- per-bank idle sleep with automatic wake.

It sits between the CPU/memory-mapping logic and the SPRAM hard macros.

Parameters:
BANKS, 2, number of SPRAM banks; legal values 1, 2, 4; any other value is a synthesis error.
CLEAR_ON_RESET, 1, 1 = write zero to every word after reset before accepting requests; 0 = skip the clear.
SLEEP_IDLE, 256, idle cycles before a bank enters SLEEP; 0 disables sleep.
WAKE_CYCLES, 3, cycles a bank is held out of SLEEP before it may be accessed; legal range 1..15.

Ports:
clk  in  1  single system clock; all logic on rising edge.
rst_n  in  1  synchronous, active-low reset.
req  in  1  request valid.
we  in  1  1 = write, 0 = read; qualified by req.
addr  in  AW  word address, AW = 14 + log2(BANKS); upper log2(BANKS) bits select the bank.
in  in  16  write data.
wmask  in  4  nibble write enable; bit n enables in[4n+3:4n].
ready  out  1  request accepted this cycle when req && ready.
out  out  16  read data.
rvalid  out  1  one-cycle pulse; out is valid for the read accepted on the previous cycle.
init_done  out  1  high once the clear is finished (or immediately after reset if CLEAR_ON_RESET=0).

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset values:
  - ready=0, rvalid=0, out=0, init_done=0;
  - all banks awake;
  - idle counters=0;
  - FSM goes to CLEAR if CLEAR_ON_RESET=1, else to RUN.
- FSM states: CLEAR, RUN, WAKE.
- CLEAR:
  - 14-bit counter runs 0..16383, writing 16'h0000 with mask 4'b1111 to that address in all banks in parallel (16384 cycles).
  - Moves to RUN on the cycle after address 16383 is written.
  - init_done rises on entry to RUN. ready=0 throughout CLEAR.
- RUN:
  - ready is high combinationally when the addressed bank is awake; otherwise ready=0 and the FSM goes to WAKE.
  - Accepted write: WREN=1 and MASKWREN=wmask to the addressed bank only; other banks get no write. wmask=0 is accepted as a no-op write.
  - Accepted read: bank index is registered; next cycle rvalid=1 and out = that bank's DATAOUT. out holds its value until the next read completes. Writes never change out.
  - Back-to-back reads: one per cycle, rvalid high every cycle.
- Bank sleep:
  - Each bank has an idle counter. It clears on any accepted access to that bank and otherwise increments, saturating at SLEEP_IDLE.
  - When the counter reaches SLEEP_IDLE (SLEEP_IDLE != 0), SLEEP=1 for that bank.
  - CHIPSELECT=1 and STANDBY=0 always; POWEROFF=1 always (active-low: powered).
- WAKE:
  - Entered from RUN when req=1 targets a sleeping bank; clears that bank's SLEEP.
  - Counts WAKE_CYCLES cycles, then marks the bank awake, clears its idle counter and returns to RUN.
  - The pending request is not latched; the requester keeps req/addr stable and is accepted in RUN.
  - ready=0 throughout WAKE. Other banks' counters keep running.
- Reset mid-operation: rst_n=0 in any state aborts the state immediately. A pending rvalid is dropped. The clear restarts from address 0 (CLEAR_ON_RESET=1); contents are otherwise undefined.
- Address and width rules: no bounds check is needed, since addr width exactly covers the array. BANKS=1 has no bank-select bits.

Test Plan:
- Reset, CLEAR_ON_RESET=1, BANKS=2 -> ready=0 and init_done=0 for 16384 cycles; init_done=1 on the next cycle; reads of addr 0, 16383, 16384, 32767 return 16'h0000.
- Write 16'hBEEF to addr 16'h4005, then read it -> rvalid exactly one cycle after the read is accepted, out=16'hBEEF; addr 16'h0005 still reads 16'h0000.
- Write 16'h1234 to addr 7, then write 16'hABCD with wmask=4'b0101 to addr 7 -> read returns 16'h1B3D.
- Reads to addrs 1,2,3 on consecutive cycles (values 11,22,33 preloaded) -> rvalid high 3 consecutive cycles; out = 11, 22, 33; out holds 33 afterwards.
- SLEEP_IDLE=8, WAKE_CYCLES=3: no access to bank 1 for 8 cycles -> bank 1 SLEEP=1. A read to addr 16384 then gives ready=0 for 3 cycles, followed by acceptance and correct data. Bank 0 accesses during this stay ready=1 except while in WAKE.
- Assert rst_n=0 at clear address 100 -> on release the clear restarts at 0 and init_done stays low for a full 16384 cycles.
